rob_mw: RTL and testbench

- Parametrised reorder buffer, successor to the single-writeback ROB.
- Sits between issue, the execution/SLB writeback buses, the register file and the store-load buffer.
- Holds in-flight instructions in program order and accepts up to N_WB results per cycle, with same-cycle operand bypass.
- Retires one instruction per cycle, gating store retirement on an SLB acknowledge and raising a flush with the redirect PC on branch mispredict.
- Uses all 2**Q_WIDTH slots, with an explicit occupancy count and no reserved tag.

---
 rtl/rob_mw.sv | 175 +++++++++++++++++
 tb/tb_rob_mw.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mw.sv
// Reorder buffer with N_WB writeback channels, same-cycle operand bypass,
// store-ack gated retirement and branch-mispredict flush.
module rob_mw #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int N_WB           = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         issue_valid_in,
  output logic                         issue_ready_out,
  output logic [Q_WIDTH-1:0]           issue_tag_out,
  input  logic                         issue_is_store_in,
  input  logic                         issue_is_branch_in,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]        issue_predict_pc_in,
  input  logic [N_WB-1:0]              wb_valid_in,
  input  logic [N_WB*Q_WIDTH-1:0]      wb_tag_in,
  input  logic [N_WB*DATA_WIDTH-1:0]   wb_value_in,
  input  logic [N_WB*DATA_WIDTH-1:0]   wb_npc_in,
  input  logic [Q_WIDTH-1:0]           rd_tag1_in,
  input  logic [Q_WIDTH-1:0]           rd_tag2_in,
  output logic                         rd_ready1_out,
  output logic                         rd_ready2_out,
  output logic [DATA_WIDTH-1:0]        rd_value1_out,
  output logic [DATA_WIDTH-1:0]        rd_value2_out,
  output logic                         commit_valid_out,
  output logic [Q_WIDTH-1:0]           commit_tag_out,
  output logic [REG_ADDR_WIDTH-1:0]    commit_reg_addr_out,
  output logic [DATA_WIDTH-1:0]        commit_value_out,
  output logic                         commit_wr_reg_out,
  output logic                         commit_store_req_out,
  input  logic                         store_ack_in,
  output logic                         flush_out,
  output logic [DATA_WIDTH-1:0]        flush_pc_out,
  output logic [Q_WIDTH:0]             count_out,
  output logic                         empty_out,
  output logic                         full_out
);

  localparam int DEPTH = 1 << Q_WIDTH;
  localparam logic [Q_WIDTH:0] FULL_COUNT = (Q_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0]          done;
  logic [DEPTH-1:0]          is_store;
  logic [DEPTH-1:0]          is_branch;
  logic [REG_ADDR_WIDTH-1:0] reg_addr   [DEPTH];
  logic [DATA_WIDTH-1:0]     predict_pc [DEPTH];
  logic [DATA_WIDTH-1:0]     value      [DEPTH];
  logic [DATA_WIDTH-1:0]     npc        [DEPTH];
  logic [Q_WIDTH-1:0]        head;
  logic [Q_WIDTH-1:0]        tail;
  logic [Q_WIDTH:0]          count;

  logic [Q_WIDTH-1:0]        wb_tag   [N_WB];
  logic [DATA_WIDTH-1:0]     wb_value [N_WB];
  logic [DATA_WIDTH-1:0]     wb_npc   [N_WB];

  logic [Q_WIDTH-1:0]        rd_tag   [2];
  logic                      rd_ready [2];
  logic [DATA_WIDTH-1:0]     rd_value [2];

  logic full;
  logic do_issue;
  logic head_done;
  logic retire;
  logic mispredict;

  always_comb begin
    for (int i = 0; i < N_WB; i++) begin
      wb_tag[i]   = wb_tag_in[i*Q_WIDTH +: Q_WIDTH];
      wb_value[i] = wb_value_in[i*DATA_WIDTH +: DATA_WIDTH];
      wb_npc[i]   = wb_npc_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign full       = (count == FULL_COUNT);
  assign do_issue   = rdy_in && issue_valid_in && !full;
  assign head_done  = valid[head] && done[head];
  assign retire     = rdy_in && head_done && (!is_store[head] || store_ack_in);
  assign mispredict = retire && is_branch[head] && (npc[head] != predict_pc[head]);

  assign rd_tag[0] = rd_tag1_in;
  assign rd_tag[1] = rd_tag2_in;

  // Later channels overwrite earlier ones, so the highest index wins the bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_ready[p] = done[rd_tag[p]];
      rd_value[p] = value[rd_tag[p]];
      for (int i = 0; i < N_WB; i++) begin
        if (wb_valid_in[i] && (wb_tag[i] == rd_tag[p])) begin
          rd_ready[p] = 1'b1;
          rd_value[p] = wb_value[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        valid <= '0;
        done  <= '0;
      end else begin
        for (int i = 0; i < N_WB; i++) begin
          if (wb_valid_in[i] && valid[wb_tag[i]]) begin
            done[wb_tag[i]] <= 1'b1;
          end
        end
        // The retire clear follows the writeback so a late write to the head cannot revive it.
        if (retire) begin
          valid[head] <= 1'b0;
          done[head]  <= 1'b0;
          head        <= head + 1'b1;
        end
        if (do_issue) begin
          valid[tail] <= 1'b1;
          done[tail]  <= 1'b0;
          tail        <= tail + 1'b1;
        end
        count <= count + (Q_WIDTH+1)'(do_issue) - (Q_WIDTH+1)'(retire);
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind valid/done.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !mispredict) begin
      if (do_issue) begin
        is_store[tail]   <= issue_is_store_in;
        is_branch[tail]  <= issue_is_branch_in;
        reg_addr[tail]   <= issue_reg_addr_in;
        predict_pc[tail] <= issue_predict_pc_in;
      end
      for (int i = 0; i < N_WB; i++) begin
        if (wb_valid_in[i] && valid[wb_tag[i]]) begin
          value[wb_tag[i]] <= wb_value[i];
          npc[wb_tag[i]]   <= wb_npc[i];
        end
      end
    end
  end

  assign issue_ready_out      = !full;
  assign issue_tag_out        = tail;
  assign rd_ready1_out        = rd_ready[0];
  assign rd_ready2_out        = rd_ready[1];
  assign rd_value1_out        = rd_value[0];
  assign rd_value2_out        = rd_value[1];
  assign commit_valid_out     = retire;
  assign commit_tag_out       = head;
  assign commit_reg_addr_out  = reg_addr[head];
  assign commit_value_out     = value[head];
  assign commit_wr_reg_out    = retire && !is_store[head] && !is_branch[head];
  assign commit_store_req_out = rdy_in && head_done && is_store[head];
  assign flush_out            = mispredict;
  assign flush_pc_out         = npc[head];
  assign count_out            = count;
  assign empty_out            = (count == '0);
  assign full_out             = full;

endmodule

// File: tb/tb_rob_mw.sv
// Scoreboard bench for rob_mw: a program-order queue model predicts per-cycle
// status and every retirement; a monitor process pops and compares.
module tb_rob_mw;

  localparam int RW = 5;
  localparam int QW = 4;
  localparam int DW = 32;
  localparam int NW = 2;
  localparam int DEPTH = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic issue_valid_in = 1'b0;
  logic issue_ready_out;
  logic [QW-1:0] issue_tag_out;
  logic issue_is_store_in = 1'b0;
  logic issue_is_branch_in = 1'b0;
  logic [RW-1:0] issue_reg_addr_in = '0;
  logic [DW-1:0] issue_predict_pc_in = '0;
  logic [NW-1:0] wb_valid_in = '0;
  logic [NW*QW-1:0] wb_tag_in = '0;
  logic [NW*DW-1:0] wb_value_in = '0;
  logic [NW*DW-1:0] wb_npc_in = '0;
  logic [QW-1:0] rd_tag1_in = '0;
  logic [QW-1:0] rd_tag2_in = '0;
  logic rd_ready1_out, rd_ready2_out;
  logic [DW-1:0] rd_value1_out, rd_value2_out;
  logic commit_valid_out;
  logic [QW-1:0] commit_tag_out;
  logic [RW-1:0] commit_reg_addr_out;
  logic [DW-1:0] commit_value_out;
  logic commit_wr_reg_out;
  logic commit_store_req_out;
  logic store_ack_in = 1'b0;
  logic flush_out;
  logic [DW-1:0] flush_pc_out;
  logic [QW:0] count_out;
  logic empty_out;
  logic full_out;

  rob_mw #(.REG_ADDR_WIDTH(RW), .Q_WIDTH(QW), .DATA_WIDTH(DW), .N_WB(NW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .issue_tag_out(issue_tag_out), .issue_is_store_in(issue_is_store_in),
    .issue_is_branch_in(issue_is_branch_in), .issue_reg_addr_in(issue_reg_addr_in),
    .issue_predict_pc_in(issue_predict_pc_in),
    .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
    .wb_npc_in(wb_npc_in),
    .rd_tag1_in(rd_tag1_in), .rd_tag2_in(rd_tag2_in),
    .rd_ready1_out(rd_ready1_out), .rd_ready2_out(rd_ready2_out),
    .rd_value1_out(rd_value1_out), .rd_value2_out(rd_value2_out),
    .commit_valid_out(commit_valid_out), .commit_tag_out(commit_tag_out),
    .commit_reg_addr_out(commit_reg_addr_out), .commit_value_out(commit_value_out),
    .commit_wr_reg_out(commit_wr_reg_out), .commit_store_req_out(commit_store_req_out),
    .store_ack_in(store_ack_in), .flush_out(flush_out), .flush_pc_out(flush_pc_out),
    .count_out(count_out), .empty_out(empty_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [QW-1:0] tag;
    bit            store;
    bit            branch;
    logic [RW-1:0] rd;
    logic [DW-1:0] ppc;
    logic [DW-1:0] value;
    logic [DW-1:0] npc;
    bit            done;
  } ent_t;

  typedef struct {
    int            count;
    logic [QW-1:0] itag;
    bit            commit;
    bit            store_req;
    bit            ready1;
    bit            ready2;
    logic [DW-1:0] val1;
    logic [DW-1:0] val2;
  } status_t;

  typedef struct {
    logic [QW-1:0] tag;
    logic [RW-1:0] rd;
    logic [DW-1:0] value;
    bit            wr_reg;
    bit            flush;
    logic [DW-1:0] flush_pc;
  } commit_t;

  ent_t    rob_q[$];
  status_t status_q[$];
  commit_t commit_q[$];
  logic [QW-1:0] next_tag = '0;
  int checks = 0;
  int errors = 0;

  bit            s_issue, s_store, s_branch, s_ack, s_rdy;
  logic [RW-1:0] s_rd;
  logic [DW-1:0] s_ppc;
  bit            s_wb_v   [NW];
  logic [QW-1:0] s_wb_tag [NW];
  logic [DW-1:0] s_wb_val [NW];
  logic [DW-1:0] s_wb_npc [NW];
  logic [QW-1:0] s_rd1, s_rd2;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int find_tag(input logic [QW-1:0] t);
    foreach (rob_q[k]) if (rob_q[k].tag == t) return k;
    return -1;
  endfunction

  task automatic model_lookup(input logic [QW-1:0] t, output bit rdy, output logic [DW-1:0] val);
    int k;
    k = find_tag(t);
    rdy = 0;
    val = '0;
    if (k >= 0 && rob_q[k].done) begin
      rdy = 1;
      val = rob_q[k].value;
    end
    for (int i = 0; i < NW; i++) begin
      if (s_wb_v[i] && s_wb_tag[i] == t) begin
        rdy = 1;
        val = s_wb_val[i];
      end
    end
  endtask

  task automatic clear_stim();
    s_issue = 0; s_store = 0; s_branch = 0; s_ack = 0; s_rdy = 1;
    s_rd = '0; s_ppc = '0; s_rd1 = '0; s_rd2 = '0;
    for (int i = 0; i < NW; i++) begin
      s_wb_v[i] = 0; s_wb_tag[i] = '0; s_wb_val[i] = '0; s_wb_npc[i] = '0;
    end
  endtask

  task automatic drive_inputs();
    rdy_in = s_rdy;
    issue_valid_in = s_issue;
    issue_is_store_in = s_store;
    issue_is_branch_in = s_branch;
    issue_reg_addr_in = s_rd;
    issue_predict_pc_in = s_ppc;
    store_ack_in = s_ack;
    rd_tag1_in = s_rd1;
    rd_tag2_in = s_rd2;
    for (int i = 0; i < NW; i++) begin
      wb_valid_in[i] = s_wb_v[i];
      wb_tag_in[i*QW +: QW] = s_wb_tag[i];
      wb_value_in[i*DW +: DW] = s_wb_val[i];
      wb_npc_in[i*DW +: DW] = s_wb_npc[i];
    end
  endtask

  // Drive one cycle of stimulus, predict this cycle's outputs and the next state.
  task automatic apply_stimulus();
    status_t st;
    commit_t cm;
    ent_t    e;
    bit      retire;
    bit      flush;
    bit      full;
    int      k;
    @(negedge clk_in);
    drive_inputs();
    #1;
    retire = 0;
    flush = 0;
    full = (rob_q.size() == DEPTH);
    st.count = rob_q.size();
    st.itag = next_tag;
    st.store_req = 0;
    model_lookup(s_rd1, st.ready1, st.val1);
    model_lookup(s_rd2, st.ready2, st.val2);
    if (s_rdy && rob_q.size() > 0 && rob_q[0].done) begin
      st.store_req = rob_q[0].store;
      retire = !rob_q[0].store || s_ack;
    end
    st.commit = retire;
    if (retire) begin
      flush = rob_q[0].branch && (rob_q[0].npc != rob_q[0].ppc);
      cm.tag = rob_q[0].tag;
      cm.rd = rob_q[0].rd;
      cm.value = rob_q[0].value;
      cm.wr_reg = !rob_q[0].store && !rob_q[0].branch;
      cm.flush = flush;
      cm.flush_pc = rob_q[0].npc;
      commit_q.push_back(cm);
    end
    status_q.push_back(st);
    if (!s_rdy) return;
    if (flush) begin
      rob_q.delete();
      next_tag = '0;
      return;
    end
    for (int i = 0; i < NW; i++) begin
      if (s_wb_v[i]) begin
        k = find_tag(s_wb_tag[i]);
        if (k >= 0) begin
          e = rob_q[k];
          e.value = s_wb_val[i];
          e.npc = s_wb_npc[i];
          e.done = 1;
          rob_q[k] = e;
        end
      end
    end
    if (retire) void'(rob_q.pop_front());
    if (s_issue && !full) begin
      e.tag = next_tag;
      e.store = s_store;
      e.branch = s_branch;
      e.rd = s_rd;
      e.ppc = s_ppc;
      e.value = '0;
      e.npc = '0;
      e.done = 0;
      rob_q.push_back(e);
      next_tag = next_tag + 1'b1;
    end
  endtask

  // Reset is raised between clock edges so the outputs must follow it asynchronously.
  task automatic do_reset();
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    clear_stim();
    drive_inputs();
    rob_q.delete();
    next_tag = '0;
    #1;
    check_output("rst_count", 32'(count_out), 0);
    check_output("rst_empty", 32'(empty_out), 1);
    check_output("rst_full", 32'(full_out), 0);
    check_output("rst_issue_ready", 32'(issue_ready_out), 1);
    check_output("rst_issue_tag", 32'(issue_tag_out), 0);
    check_output("rst_commit_valid", 32'(commit_valid_out), 0);
    check_output("rst_wr_reg", 32'(commit_wr_reg_out), 0);
    check_output("rst_store_req", 32'(commit_store_req_out), 0);
    check_output("rst_flush", 32'(flush_out), 0);
    repeat (2) @(negedge clk_in);
    #4;
    rst_in = 1'b1;
  endtask

  task automatic issue_one(input bit store, input bit branch, input logic [DW-1:0] ppc);
    clear_stim();
    s_issue = 1;
    s_store = store;
    s_branch = branch;
    s_rd = 5'($urandom_range(1, 31));
    s_ppc = ppc;
    apply_stimulus();
  endtask

  task automatic wb_one(input logic [QW-1:0] tag, input logic [DW-1:0] val, input logic [DW-1:0] npc);
    clear_stim();
    s_wb_v[0] = 1;
    s_wb_tag[0] = tag;
    s_wb_val[0] = val;
    s_wb_npc[0] = npc;
    s_rd1 = tag;
    apply_stimulus();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      clear_stim();
      s_ack = 1;
      apply_stimulus();
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && rob_q.size() > 0; c++) begin
      int n;
      n = 0;
      clear_stim();
      s_ack = 1;
      for (int k = 0; k < rob_q.size() && n < NW; k++) begin
        if (!rob_q[k].done) begin
          s_wb_v[n] = 1;
          s_wb_tag[n] = rob_q[k].tag;
          s_wb_val[n] = $urandom;
          s_wb_npc[n] = rob_q[k].ppc;
          n++;
        end
      end
      apply_stimulus();
    end
    idle(2);
  endtask

  status_t mon_st;
  commit_t mon_cm;

  always begin
    @(negedge clk_in);
    #3;
    if (rst_in && status_q.size() > 0) begin
      mon_st = status_q.pop_front();
      check_output("count", 32'(count_out), 32'(mon_st.count));
      check_output("full", 32'(full_out), 32'(mon_st.count == DEPTH));
      check_output("empty", 32'(empty_out), 32'(mon_st.count == 0));
      check_output("issue_ready", 32'(issue_ready_out), 32'(mon_st.count != DEPTH));
      check_output("issue_tag", 32'(issue_tag_out), 32'(mon_st.itag));
      check_output("commit_valid", 32'(commit_valid_out), 32'(mon_st.commit));
      check_output("store_req", 32'(commit_store_req_out), 32'(mon_st.store_req));
      check_output("rd_ready1", 32'(rd_ready1_out), 32'(mon_st.ready1));
      check_output("rd_ready2", 32'(rd_ready2_out), 32'(mon_st.ready2));
      if (mon_st.ready1) check_output("rd_value1", rd_value1_out, mon_st.val1);
      if (mon_st.ready2) check_output("rd_value2", rd_value2_out, mon_st.val2);
    end
    if (rst_in && (commit_valid_out || flush_out)) begin
      if (commit_q.size() == 0) begin
        check_output("unexpected_commit", 32'(commit_tag_out), 32'hFFFF_FFFF);
      end else begin
        mon_cm = commit_q.pop_front();
        check_output("commit_tag", 32'(commit_tag_out), 32'(mon_cm.tag));
        check_output("commit_reg", 32'(commit_reg_addr_out), 32'(mon_cm.rd));
        check_output("commit_value", commit_value_out, mon_cm.value);
        check_output("commit_wr_reg", 32'(commit_wr_reg_out), 32'(mon_cm.wr_reg));
        check_output("flush", 32'(flush_out), 32'(mon_cm.flush));
        if (mon_cm.flush) check_output("flush_pc", flush_pc_out, mon_cm.flush_pc);
      end
    end
  end

  initial begin
    clear_stim();
    do_reset();

    // In-order retirement despite out-of-order writeback.
    for (int i = 0; i < 3; i++) issue_one(0, 0, 32'h1000 + 32'(i * 4));
    wb_one(4'd1, 32'h11, '0);
    wb_one(4'd0, 32'h10, '0);
    wb_one(4'd2, 32'h12, '0);
    idle(4);

    // Fill to capacity, refused issue, then pointer wrap.
    do_reset();
    for (int i = 0; i < 17; i++) issue_one(0, 0, 32'(i));
    wb_one(4'd0, 32'h55, '0);
    issue_one(0, 0, 32'h77);
    issue_one(0, 0, 32'h78);
    issue_one(0, 0, 32'h79);
    drain();

    // Two channels hitting the same tag: highest channel wins.
    do_reset();
    for (int i = 0; i < 6; i++) issue_one(0, 0, 32'(i));
    clear_stim();
    s_wb_v[0] = 1; s_wb_tag[0] = 4'd5; s_wb_val[0] = 32'hAA;
    s_wb_v[1] = 1; s_wb_tag[1] = 4'd5; s_wb_val[1] = 32'hBB;
    s_rd1 = 4'd5;
    apply_stimulus();
    clear_stim();
    s_rd1 = 4'd5;
    s_rd2 = 4'd5;
    apply_stimulus();
    drain();

    // Store waits for its acknowledge.
    do_reset();
    issue_one(1, 0, 32'h200);
    wb_one(4'd0, 32'h5A5A, '0);
    for (int c = 0; c < 4; c++) begin
      clear_stim();
      apply_stimulus();
    end
    clear_stim();
    s_ack = 1;
    apply_stimulus();
    idle(2);

    // Mispredicted branch flushes younger entries and the same-cycle issue.
    do_reset();
    issue_one(0, 1, 32'h100);
    for (int i = 0; i < 3; i++) issue_one(0, 0, 32'h300 + 32'(i));
    wb_one(4'd0, 32'h0, 32'h104);
    issue_one(0, 0, 32'h400);
    idle(2);
    issue_one(0, 1, 32'h200);
    wb_one(4'd0, 32'h0, 32'h200);
    idle(2);

    // Asynchronous reset mid-stream, then restart from tag 0.
    do_reset();
    for (int i = 0; i < 6; i++) issue_one(0, 0, 32'(i));
    do_reset();
    issue_one(0, 0, 32'h900);
    drain();

    // Randomised traffic including stalls, stores and occasional mispredicts.
    for (int c = 0; c < 800; c++) begin
      int k;
      ent_t e;
      clear_stim();
      s_rdy = ($urandom_range(0, 9) != 0);
      s_issue = ($urandom_range(0, 9) < 6);
      s_store = ($urandom_range(0, 4) == 0);
      s_branch = !s_store && ($urandom_range(0, 5) == 0);
      s_rd = 5'($urandom);
      s_ppc = $urandom;
      s_ack = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NW; i++) begin
        s_wb_v[i] = ($urandom_range(0, 1) == 1);
        s_wb_val[i] = $urandom;
        if (rob_q.size() > 0 && $urandom_range(0, 4) != 0) begin
          k = int'($urandom_range(0, rob_q.size() - 1));
          e = rob_q[k];
          s_wb_tag[i] = e.tag;
          s_wb_npc[i] = (e.branch && $urandom_range(0, 5) == 0) ? e.ppc + 32'd4 : e.ppc;
        end else begin
          s_wb_tag[i] = 4'($urandom);
          s_wb_npc[i] = $urandom;
        end
      end
      if (rob_q.size() > 0) begin
        k = int'($urandom_range(0, rob_q.size() - 1));
        s_rd1 = rob_q[k].tag;
      end else begin
        s_rd1 = 4'($urandom);
      end
      s_rd2 = 4'($urandom);
      apply_stimulus();
    end
    drain();

    check_output("pending_commits", 32'(commit_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
